// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, widths, FSM encoding.
// The control generator imports the same MDU_OP_* constants.
package mdu_iter_pkg;

  localparam int MDU_XLEN = 64;
  localparam int MDU_WLEN = 32;

  localparam logic [2:0] MDU_OP_MUL    = 3'b000;
  localparam logic [2:0] MDU_OP_MULH   = 3'b001;
  localparam logic [2:0] MDU_OP_MULHSU = 3'b010;
  localparam logic [2:0] MDU_OP_MULHU  = 3'b011;
  localparam logic [2:0] MDU_OP_DIV    = 3'b100;
  localparam logic [2:0] MDU_OP_DIVU   = 3'b101;
  localparam logic [2:0] MDU_OP_REM    = 3'b110;
  localparam logic [2:0] MDU_OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mduState_t;

  // rs1 is treated as signed by every op except the fully unsigned ones.
  function automatic logic opSigned1(input logic [2:0] opCode);
    return (opCode != MDU_OP_MULHU) && (opCode != MDU_OP_DIVU) && (opCode != MDU_OP_REMU);
  endfunction

  function automatic logic opSigned2(input logic [2:0] opCode);
    return (opCode == MDU_OP_MUL) || (opCode == MDU_OP_MULH) ||
           (opCode == MDU_OP_DIV) || (opCode == MDU_OP_REM);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and emit the quotient bit.
module mdu_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] partRem,
  input  logic            dividendMsb,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] nextRem,
  output logic            qBit
);

  logic [XLEN:0] remShift;
  logic [XLEN:0] diff;

  // partRem < divisor, so a borrow out of the top bit means "does not fit".
  always_comb begin
    remShift = {partRem, dividendMsb};
    diff     = remShift - {1'b0, divisor};
    qBit     = ~diff[XLEN];
    nextRem  = qBit ? diff[XLEN-1:0] : remShift[XLEN-1:0];
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit: one shift-add or restoring-subtract step
// per cycle on operand magnitudes, signs and W extension applied on the last step.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int XLEN = MDU_XLEN,
  parameter int WLEN = MDU_WLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            is_word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] STEPS_X = CW'(XLEN);
  localparam logic [CW-1:0] STEPS_W = CW'(WLEN);
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] extWord(input logic [XLEN-1:0] v, input logic sgn);
    return {{(XLEN-WLEN){sgn & v[WLEN-1]}}, v[WLEN-1:0]};
  endfunction

  function automatic logic [XLEN-1:0] condNeg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] condNeg2(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  mduState_t state, stateNext;
  logic [CW-1:0] cnt;
  logic accept, calcDone;

  logic s1Signed, s2Signed, negA, negB, divByZero, sgnOvf, special;
  logic signed [XLEN-1:0] opA, opB;
  logic [XLEN-1:0] magA, magB, minVal, specRaw, specRes;

  logic [2:0]      opReg;
  logic            wordReg, negAReg, negBReg;
  logic [XLEN-1:0] hiReg, loReg, mcandReg;

  logic [XLEN:0]     mulSum;
  logic [XLEN-1:0]   divRem, nextHi, nextLo, quoFix, remFix, mulSel, rawSel, finalRes;
  logic              divQ;
  logic [2*XLEN-1:0] prodRaw, prodFix;

  // Request decode: W prep, magnitudes and the no-iteration divide cases
  always_comb begin
    s1Signed  = opSigned1(op);
    s2Signed  = opSigned2(op);
    opA       = is_word ? extWord(src1, s1Signed) : src1;
    opB       = is_word ? extWord(src2, s2Signed) : src2;
    negA      = s1Signed & opA[XLEN-1];
    negB      = s2Signed & opB[XLEN-1];
    magA      = condNeg(opA, negA);
    magB      = condNeg(opB, negB);
    minVal    = is_word ? MIN_W : MIN_X;
    divByZero = op[2] && (opB == '0);
    sgnOvf    = ((op == MDU_OP_DIV) || (op == MDU_OP_REM)) && (opA == minVal) && (opB == '1);
    special   = divByZero || sgnOvf;
    if (divByZero) specRaw = op[1] ? opA : '1;
    else           specRaw = op[1] ? '0 : minVal;
    specRes   = is_word ? extWord(specRaw, 1'b1) : specRaw;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          stateNext = special ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: if (cnt == CW'(1)) stateNext = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) stateNext = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
    if (flush) begin
      stateNext = ST_IDLE;
      accept    = 1'b0;
    end
    calcDone = (state == ST_CALC) && (stateNext == ST_DONE);
  end

  mdu_div_step #(.XLEN(XLEN)) uDivStep (
    .partRem     (hiReg),
    .dividendMsb (loReg[XLEN-1]),
    .divisor     (mcandReg),
    .nextRem     (divRem),
    .qBit        (divQ)
  );

  // Iteration step: hi/lo hold product or remainder/quotient; result formed on the last step
  always_comb begin
    mulSum = {1'b0, hiReg} + {1'b0, mcandReg & {XLEN{loReg[0]}}};
    if (opReg[2]) begin
      nextHi = divRem;
      nextLo = {loReg[XLEN-2:0], divQ};
    end else begin
      nextHi = mulSum[XLEN:1];
      nextLo = {mulSum[0], loReg[XLEN-1:1]};
    end
    prodRaw  = wordReg ? ({nextHi, nextLo} >> WLEN) : {nextHi, nextLo};
    prodFix  = condNeg2(prodRaw, negAReg ^ negBReg);
    mulSel   = (opReg == MDU_OP_MUL) ? prodFix[XLEN-1:0] : prodFix[2*XLEN-1:XLEN];
    quoFix   = condNeg(nextLo, negAReg ^ negBReg);
    remFix   = condNeg(nextHi, negAReg);
    rawSel   = opReg[2] ? (opReg[1] ? remFix : quoFix) : mulSel;
    finalRes = wordReg ? extWord(rawSel, 1'b1) : rawSel;
  end

  // Datapath registers carry no reset; they are always loaded on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      opReg   <= op;
      wordReg <= is_word;
      negAReg <= negA;
      negBReg <= negB;
      hiReg   <= '0;
      if (op[2]) begin
        mcandReg <= magB;
        loReg    <= is_word ? (magA << WLEN) : magA;
      end else begin
        mcandReg <= magA;
        loReg    <= magB;
      end
    end else if (state == ST_CALC) begin
      hiReg <= nextHi;
      loReg <= nextLo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      result <= '0;
    end else begin
      if (accept)                 cnt <= is_word ? STEPS_W : STEPS_X;
      else if (state == ST_CALC)  cnt <= cnt - 1'b1;
      if (accept && special)      result <= specRes;
      else if (calcDone)          result <= finalRes;
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: directed requests push expected result/latency,
// an independent monitor pops and compares on each output handshake.
module tb_mdu_iter;
  import mdu_iter_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, is_word, flush, out_valid, out_ready;
  logic [2:0]  op;
  logic [63:0] src1, src2, result;

  typedef struct {
    string       name;
    logic [63:0] res;
    int          lat;
    int          accCyc;
  } expEntry_t;

  expEntry_t sbQ[$];
  int nTests = 0;
  int nFail = 0;
  int cyc = 0;
  int firstCyc = 0;
  bit seenValid = 1'b0;

  mdu_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .is_word   (is_word),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic failNow(input string name);
    nTests++;
    nFail++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  // Waits for in_ready, presents one request; accept happens at the next posedge.
  task automatic issue(input string name, input logic [2:0] o, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] expRes, input int expLat, input bit doPush);
    int guard = 0;
    expEntry_t e;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      failNow({name, "_in_ready"});
      return;
    end
    in_valid = 1'b1;
    op       = o;
    is_word  = w;
    src1     = a;
    src2     = b;
    if (doPush) begin
      e.name   = name;
      e.res    = expRes;
      e.lat    = expLat;
      e.accCyc = cyc + 1;
      sbQ.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sbQ.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (sbQ.size() != 0) failNow("drain");
  endtask

  // Monitor: latency counts posedges from accept to the edge sampling out_valid high
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !seenValid) begin
        seenValid = 1'b1;
        firstCyc  = cyc;
      end
      if (out_valid && out_ready) begin
        if (sbQ.size() == 0) begin
          nTests++;
          nFail++;
          $display("FAIL unexpected_output: got %h expected no output", result);
        end else begin
          expEntry_t e;
          e = sbQ.pop_front();
          check(e.name, result, e.res);
          check({e.name, "_lat"}, 64'(firstCyc - e.accCyc + 1), 64'(e.lat));
        end
        seenValid = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit sawValid;
    int guard;
    rst = 1'b1; in_valid = 1'b0; op = 3'b000; is_word = 1'b0;
    src1 = '0; src2 = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_result", result, 64'd0);
    rst = 1'b0;

    issue("mul_7x-3",   MDU_OP_MUL,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, 1'b1);
    issue("mulhu",      MDU_OP_MULHU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 65, 1'b1);
    issue("mulh_-1-1",  MDU_OP_MULH,   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65, 1'b1);
    issue("mulhsu",     MDU_OP_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b1);
    issue("div_-7/2",   MDU_OP_DIV,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 1'b1);
    issue("rem_-7/2",   MDU_OP_REM,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b1);
    issue("divu_100/7", MDU_OP_DIVU,   1'b0, 64'd100, 64'd7, 64'd14, 65, 1'b1);
    issue("divuw",      MDU_OP_DIVU,   1'b1, 64'h1_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33, 1'b1);
    issue("mulw",       MDU_OP_MUL,    1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, 1'b1);
    issue("remw_-7/2",  MDU_OP_REM,    1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33, 1'b1);
    issue("div_by0",    MDU_OP_DIV,    1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b1);
    issue("rem_by0",    MDU_OP_REM,    1'b0, 64'h1234, 64'd0, 64'h1234, 1, 1'b1);
    issue("divw_ovf",   MDU_OP_DIV,    1'b1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 1'b1);
    issue("rem_ovf",    MDU_OP_REM,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 1'b1);
    drain();

    // Output back-pressure: result and in_ready must hold while out_ready is low
    out_ready = 1'b0;
    issue("mul_stall", MDU_OP_MUL, 1'b0, 64'd5, 64'd6, 64'd30, 65, 1'b1);
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!out_valid) failNow("stall_wait");
    for (int i = 0; i < 5; i++) begin
      check("stall_result", result, 64'd30);
      check("stall_in_ready", {63'd0, in_ready}, 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Flush in CALC: request dropped, no output, unit usable again
    issue("flush_mul", MDU_OP_MUL, 1'b0, 64'd9, 64'd9, 64'd0, 0, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    sawValid = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) sawValid = 1'b1;
    end
    check("flush_no_output", {63'd0, sawValid}, 64'd0);
    issue("mul_3x4", MDU_OP_MUL, 1'b0, 64'd3, 64'd4, 64'd12, 65, 1'b1);
    drain();

    // Reset mid-operation clears result and returns to idle
    issue("rst_div", MDU_OP_DIV, 1'b0, 64'd100, 64'd7, 64'd0, 0, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result", result, 64'd0);
    rst = 1'b0;
    issue("remu_100/7", MDU_OP_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 65, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
